// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter that lets one draw engine at a time drive the VGA write port.
// It releases the winning engine's reset, forwards its pixels and waits for done or a watchdog.
module draw_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] src_x,
    input  logic [7*N_REQ-1:0] src_y,
    input  logic [9*N_REQ-1:0] src_colour,
    input  logic [N_REQ-1:0]   src_done,
    output logic [N_REQ-1:0]   run,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [8:0]         vga_colour,
    output logic               vga_plot,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic [N_REQ-1:0]   grant_done,
    output logic               timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARM, DRAW, RELEASE} state_t;

    state_t          state_reg;
    logic [1:0]      ptr_reg;
    logic            arm_reg;
    logic [WD_W-1:0] wdog_reg;

    logic [7:0] x_arr [N_REQ];
    logic [6:0] y_arr [N_REQ];
    logic [8:0] c_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign x_arr[gi] = src_x[8*gi +: 8];
        assign y_arr[gi] = src_y[7*gi +: 7];
        assign c_arr[gi] = src_colour[9*gi +: 9];
    end

    // First requester found after the last grant, wrapping modulo N_REQ.
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    always_comb begin
        winner = ptr_reg;
        cand   = ptr_reg;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = 2'((int'(ptr_reg) + k) % N_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'(N_REQ - 1);
            arm_reg     <= 1'b0;
            wdog_reg    <= '0;
            run         <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            grant_id    <= '0;
            grant_done  <= '0;
            timeout_err <= 1'b0;
        end else begin
            grant_done  <= '0;
            timeout_err <= 1'b0;
            vga_plot    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        grant_id  <= winner;
                        run       <= ONE << winner;
                        wdog_reg  <= '0;
                        arm_reg   <= 1'b0;
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    // Two cycles: engine leaves reset, then its ROM read settles.
                    arm_reg <= 1'b1;
                    if (arm_reg) begin
                        state_reg <= DRAW;
                    end
                end
                DRAW: begin
                    vga_x      <= x_arr[grant_id];
                    vga_y      <= y_arr[grant_id];
                    vga_colour <= c_arr[grant_id];
                    if (src_done[grant_id]) begin
                        grant_done <= ONE << grant_id;
                        state_reg  <= RELEASE;
                    end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state_reg   <= RELEASE;
                    end else begin
                        vga_plot <= 1'b1;
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    run       <= '0;
                    ptr_reg   <= grant_id;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_port_arbiter.sv
// Scoreboard bench for draw_port_arbiter with four modelled draw engines.
// Expected grants are queued by the stimulus; a negedge monitor checks pixels and completions.
module tb_draw_port_arbiter;
    localparam int N   = 4;
    localparam int TMO = 4096;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    wire  [31:0] src_x;
    wire  [27:0] src_y;
    wire  [35:0] src_colour;
    wire  [3:0]  src_done;
    logic [3:0]  run;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [8:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic [1:0]  grant_id;
    logic [3:0]  grant_done;
    logic        timeout_err;

    draw_port_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .src_x(src_x), .src_y(src_y), .src_colour(src_colour), .src_done(src_done),
        .run(run), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .grant_id(grant_id),
        .grant_done(grant_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] c;
    } pix_t;

    // Pixel p of engine i; distinct per engine and never all-ones at p=0.
    function automatic pix_t pix(int i, int p);
        pix_t r;
        r.x = 8'(p * 7 + 40 * i + 3);
        r.y = 7'((p >> 3) + 9 * i + 1);
        r.c = 9'(p * 5 + 77 * i + 1);
        return r;
    endfunction

    int npix_cfg [4];

    // Engine model: held in reset while run is low; pixel 0 appears two cycles after release.
    for (genvar gi = 0; gi < 4; gi++) begin : eng
        int   cnt = 0;
        pix_t cur;
        always @(posedge clk or negedge run[gi]) begin
            if (!run[gi]) cnt <= 0;
            else          cnt <= cnt + 1;
        end
        always_comb begin
            if (cnt >= 2) cur = pix(gi, cnt - 2);
            else          cur = '1;
        end
        assign src_x[8*gi +: 8]      = cur.x;
        assign src_y[7*gi +: 7]      = cur.y;
        assign src_colour[9*gi +: 9] = cur.c;
        assign src_done[gi]          = run[gi] && (cnt >= 2 + npix_cfg[gi]);
    end

    typedef struct {
        int id;
        bit tmo;
        int npix;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       e;
    int         tests   = 0;
    int         fails   = 0;
    int         events  = 0;
    int         pix_cnt = 0;
    int         run0_cycles = 0;
    logic [3:0] prev_run = '0;
    logic [3:0] want_gd;
    pix_t       got_p;
    pix_t       want_p;

    always @(negedge clk) begin
        if (run[0]) run0_cycles++;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_run = '0;
        end else begin
            tests++;
            if (!$onehot0(run)) begin
                fails++;
                $display("FAIL run_onehot: run=%b required at most one bit", run);
            end
            if (run !== prev_run) begin
                tests++;
                if (prev_run != 0 && run != 0) begin
                    fails++;
                    $display("FAIL run_gap: run went %b -> %b, required a zero cycle between", prev_run, run);
                end
            end
            prev_run = run;
            if (vga_plot) begin
                tests++;
                got_p = {vga_x, vga_y, vga_colour};
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_plot: x=%0d y=%0d c=%0d with no grant expected", vga_x, vga_y, vga_colour);
                end else begin
                    want_p = pix(exp_q[0].id, pix_cnt);
                    if (got_p !== want_p) begin
                        fails++;
                        $display("FAIL pixel eng%0d #%0d: got x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                                 exp_q[0].id, pix_cnt, got_p.x, got_p.y, got_p.c, want_p.x, want_p.y, want_p.c);
                    end
                end
                pix_cnt++;
            end
            if (grant_done != 0 || timeout_err) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_release: grant_done=%b timeout_err=%b", grant_done, timeout_err);
                end else begin
                    e = exp_q.pop_front();
                    want_gd = e.tmo ? 4'b0000 : (4'b0001 << e.id);
                    if (grant_id !== 2'(e.id) || timeout_err !== e.tmo ||
                        grant_done !== want_gd || pix_cnt != e.npix) begin
                        fails++;
                        $display("FAIL release: got id=%0d tmo=%b gd=%b plots=%0d required id=%0d tmo=%b gd=%b plots=%0d",
                                 grant_id, timeout_err, grant_done, pix_cnt, e.id, e.tmo, want_gd, e.npix);
                    end
                end
                pix_cnt = 0;
                events++;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req_v);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_events(int target, int budget);
        int c = 0;
        while (events < target && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("wait_events", events, target);
    endtask

    task automatic wait_run(logic [3:0] pat, int budget);
        int c = 0;
        while (run !== pat && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("wait_run", run, pat);
    endtask

    task automatic push(int id, bit tmo, int n);
        exp_t x;
        x.id = id; x.tmo = tmo; x.npix = n;
        exp_q.push_back(x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int c;
        for (int i = 0; i < 4; i++) npix_cfg[i] = 5;

        // Reset values.
        wait_cyc(2);
        check("rst_run", run, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_vga_colour", vga_colour, 0);
        check("rst_vga_plot", vga_plot, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_grant_done", grant_done, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Single engine drawing a full 80x40+2 image.
        npix_cfg[0] = 3202;
        push(0, 1'b0, 3202);
        run0_cycles = 0;
        reset = 1'b0;
        req = 4'b0001;
        wait_run(4'b0001, 10);
        req = 4'b0000;
        wait_events(1, 4000);
        check("busy_in_release", busy, 1);
        check("run_in_release", run, 4'b0001);
        wait_cyc(1);
        check("busy_after_release", busy, 0);
        check("run_after_release", run, 0);
        // Two ARM cycles, 3202 plot cycles, the done cycle and the RELEASE cycle.
        check("run0_high_cycles", run0_cycles, 3202 + 4);

        // Round robin from reset with all requests held.
        reset = 1'b1;
        wait_cyc(2);
        npix_cfg[0] = 5; npix_cfg[1] = 3; npix_cfg[2] = 4; npix_cfg[3] = 6;
        push(0, 1'b0, 5); push(1, 1'b0, 3); push(2, 1'b0, 4); push(3, 1'b0, 6); push(0, 1'b0, 5);
        base = events;
        reset = 1'b0;
        req = 4'b1111;
        wait_events(base + 4, 300);
        wait_run(4'b0001, 20);
        req = 4'b0000;
        wait_events(base + 5, 100);
        wait_cyc(2);
        check("rr_idle_busy", busy, 0);
        check("rr_idle_run", run, 0);

        // Engine 0 has first priority only nominally; with req=1010, engine 1 wins then 3.
        reset = 1'b1;
        req = 4'b1010;
        wait_cyc(2);
        npix_cfg[1] = 4; npix_cfg[3] = 7;
        push(1, 1'b0, 4); push(3, 1'b0, 7);
        base = events;
        reset = 1'b0;
        wait_run(4'b1000, 60);
        req = 4'b0000;
        wait_events(base + 2, 100);

        // Watchdog: engine 2 never finishes.
        npix_cfg[2] = 1_000_000;
        push(2, 1'b1, TMO - 1);
        base = events;
        req = 4'b0100;
        wait_run(4'b0100, 20);
        req = 4'b0000;
        wait_events(base + 1, TMO + 50);
        check("tmo_run_hold", run, 4'b0100);
        wait_cyc(1);
        check("tmo_run_drop", run, 0);
        check("tmo_pulse_width", timeout_err, 0);

        // Done on the watchdog's final cycle beats the timeout; same engine re-wins.
        npix_cfg[2] = TMO - 1;
        push(2, 1'b0, TMO - 1);
        base = events;
        req = 4'b0100;
        wait_run(4'b0100, 20);
        req = 4'b0000;
        wait_events(base + 1, TMO + 50);
        wait_cyc(1);
        check("coll_timeout_err", timeout_err, 0);
        check("coll_grant_done_width", grant_done, 0);

        // Asynchronous reset in the middle of engine 2's draw, then a clean redraw.
        npix_cfg[2] = 300;
        push(2, 1'b0, 300);
        req = 4'b0100;
        wait_run(4'b0100, 20);
        c = 0;
        while (pix_cnt < 100 && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("mid_draw_pixels", pix_cnt, 100);
        #2;
        reset = 1'b1;
        #1;
        check("async_run", run, 0);
        check("async_plot", vga_plot, 0);
        check("async_busy", busy, 0);
        exp_q.delete();
        pix_cnt = 0;
        push(2, 1'b0, 300);
        base = events;
        wait_cyc(2);
        reset = 1'b0;
        wait_run(4'b0100, 20);
        req = 4'b0000;
        wait_events(base + 1, 400);

        wait_cyc(3);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
